// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   MD_WIDTH        default operand / HI / LO width (also the iteration count)
//   MD_MULT..MD_DIVU  id_ex_mdop opcode values
//   md_state_t      sequencer FSM states
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer signal bundle.
//   id_ex_mdstart/mdop/rega/regb   start request and operands
//   id_ex_readhilo/mthi/mtlo       HI/LO accesses from the pipeline
//   ex_if_stall                    pipeline freeze request
//   ex_md_hi/lo/busy/done/divzero  sequencer results and status
// master = pipeline side, slave = sequencer side.
interface muldiv_sequencer_if
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
);
    logic             id_ex_mdstart;
    logic [1:0]       id_ex_mdop;
    logic [WIDTH-1:0] id_ex_rega;
    logic [WIDTH-1:0] id_ex_regb;
    logic             id_ex_readhilo;
    logic             id_ex_mthi;
    logic             id_ex_mtlo;
    logic             ex_if_stall;
    logic [WIDTH-1:0] ex_md_hi;
    logic [WIDTH-1:0] ex_md_lo;
    logic             ex_md_busy;
    logic             ex_md_done;
    logic             ex_md_divzero;

    modport master (
        output id_ex_mdstart, id_ex_mdop, id_ex_rega, id_ex_regb,
        output id_ex_readhilo, id_ex_mthi, id_ex_mtlo,
        input  ex_if_stall, ex_md_hi, ex_md_lo, ex_md_busy, ex_md_done, ex_md_divzero
    );

    modport slave (
        input  id_ex_mdstart, id_ex_mdop, id_ex_rega, id_ex_regb,
        input  id_ex_readhilo, id_ex_mthi, id_ex_mtlo,
        output ex_if_stall, ex_md_hi, ex_md_lo, ex_md_busy, ex_md_done, ex_md_divzero
    );

endinterface

// File: rtl/muldiv_sequencer_datapath.sv
// Shift-add multiplier / restoring divider datapath.
//   clock, reset      clock, async active-high reset
//   i_load            latch operand magnitudes and sign flags
//   i_step            perform one multiply or divide iteration
//   i_is_div          selects divide step and divide result mapping
//   i_fix             fold the sign correction back into the registers
//   i_signed          operands are two's complement (MULT/DIV)
//   i_a, i_b          operand A (multiplicand/dividend), B (multiplier/divisor)
//   o_hi, o_lo        sign-corrected result (remainder/quotient for divide)
module muldiv_datapath
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic             i_fix,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic               r_sign_q;
    logic               r_sign_r;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    always_comb begin
        w_sa    = i_signed & i_a[WIDTH-1];
        w_sb    = i_signed & i_b[WIDTH-1];
        w_a_mag = w_sa ? (~i_a + 1'b1) : i_a;
        w_b_mag = w_sb ? (~i_b + 1'b1) : i_b;

        // Multiply: {carry, HI, LO} shifts right; LO starts as the multiplier.
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

        // Divide: {HI, LO} shifts left; HI is the partial remainder,
        // LO shifts the dividend out and the quotient bits in.
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_b};

        w_prod     = {r_hi, r_lo};
        w_prod_fix = r_sign_q ? (~w_prod + 1'b1) : w_prod;
        w_quo_fix  = r_sign_q ? (~r_lo + 1'b1) : r_lo;
        w_rem_fix  = r_sign_r ? (~r_hi + 1'b1) : r_hi;

        o_hi = i_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
        o_lo = i_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_b      <= w_b_mag;
            r_sign_q <= w_sa ^ w_sb;
            r_sign_r <= w_sa;
        end else if (i_step) begin
            if (i_is_div) begin
                if (!w_diff[WIDTH]) begin
                    r_hi <= w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end else if (i_fix) begin
            // Registers now hold the final signed result; clearing the
            // flags keeps o_hi/o_lo stable afterwards.
            r_hi     <= o_hi;
            r_lo     <= o_lo;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide controller for the Execute stage. Owns HI/LO,
// sequences WIDTH shift-add / restoring-divide steps and stalls the front
// end while a new mult/div or any HI/LO access would collide with it.
//   clock, reset   clock, async active-high reset
//   bus (slave)    id_ex_* requests in; ex_if_stall and ex_md_* out
module muldiv_sequencer
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t        r_state;
    md_state_t        w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_divzero;
    logic             r_is_div;

    logic             w_idle;
    logic             w_accept;
    logic             w_dz;
    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_mt_ok;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_comb begin
        w_next   = r_state;
        w_step   = 1'b0;
        w_fix    = 1'b0;
        w_idle   = (r_state == S_IDLE);
        w_accept = w_idle & bus.id_ex_mdstart;
        w_dz     = bus.id_ex_mdop[1] & (bus.id_ex_regb == '0);
        w_load   = w_accept & ~w_dz;
        // A start wins over a simultaneous MTHI/MTLO.
        w_mt_ok  = w_idle & ~bus.id_ex_mdstart;

        case (r_state)
            S_IDLE: begin
                if (bus.id_ex_mdstart) begin
                    // Divide-by-zero skips the iterations entirely.
                    w_next = w_dz ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_count == CW'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_fix  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (r_is_div),
        .i_fix    (w_fix & ~r_divzero),
        .i_signed (~bus.id_ex_mdop[0]),
        .i_a      (bus.id_ex_rega),
        .i_b      (bus.id_ex_regb),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_is_div  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;

            if (w_accept) begin
                r_count   <= '0;
                r_is_div  <= bus.id_ex_mdop[1];
                r_divzero <= w_dz;
            end else if (w_step) begin
                r_count <= r_count + CW'(1);
            end

            // In FIX, r_divzero tells whether this pass came from a
            // zero-divisor start (no HI/LO update, no done pulse).
            if (w_fix && !r_divzero) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_done <= 1'b1;
            end else if (w_mt_ok) begin
                if (bus.id_ex_mthi) r_hi <= bus.id_ex_rega;
                if (bus.id_ex_mtlo) r_lo <= bus.id_ex_rega;
            end
        end
    end

    always_comb begin
        bus.ex_md_busy    = ~w_idle;
        bus.ex_if_stall   = ~w_idle & (bus.id_ex_mdstart | bus.id_ex_readhilo |
                                       bus.id_ex_mthi | bus.id_ex_mtlo);
        bus.ex_md_hi      = r_hi;
        bus.ex_md_lo      = r_lo;
        bus.ex_md_done    = r_done;
        bus.ex_md_divzero = r_divzero;
    end

endmodule
